sar_logic_gen2: RTL and testbench

- Parametrised successor to the 8-bit SAR controller.
- Drives the capacitive DAC control words (ctlp/ctln), the sample switch and the gated comparator clock (clkc).
- Runs comparator offset-trim calibration with a configurable vote length.
- Adds a result valid/ready handshake with backpressure and a continuous back-to-back conversion mode.
- Sits between the comparator/CDAC analog macro and the digital result consumer.

---
 rtl/sar_logic_gen2.sv | 191 +++++++++++++++++++
 tb/tb_sar_logic_gen2.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_logic_gen2.sv
// SAR ADC controller: drives the CDAC control words, sample switch and gated
// comparator clock, runs comparator trim calibration and hands results out over valid/ready.
module sar_logic_gen2 #(
  parameter int unsigned NBITS         = 8,
  parameter int unsigned TRIM_BITS     = 5,
  parameter int unsigned CAL_ITERS     = 8,
  parameter int unsigned SAMPLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 cal,
  input  logic                 cont,
  input  logic                 comp,
  input  logic                 ready,
  output logic                 valid,
  output logic [NBITS-1:0]     result,
  output logic                 sample,
  output logic [NBITS-1:0]     ctlp,
  output logic [NBITS-1:0]     ctln,
  output logic [TRIM_BITS-1:0] trim,
  output logic [TRIM_BITS-1:0] trimb,
  output logic                 cal_busy,
  output logic                 clkc
);

  localparam int unsigned SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int unsigned ITW = $clog2(CAL_ITERS);
  localparam int unsigned ONW = $clog2(CAL_ITERS + 1);

  localparam logic [NBITS-1:0]     MSB     = NBITS'(1) << (NBITS - 1);
  localparam logic [TRIM_BITS-1:0] TMSB    = TRIM_BITS'(1) << (TRIM_BITS - 1);
  localparam logic [SCW-1:0]       SC_LAST = SCW'(SAMPLE_CYCLES - 1);
  localparam logic [ITW-1:0]       IT_LAST = ITW'(CAL_ITERS - 1);
  localparam logic [ONW-1:0]       HALF    = ONW'(CAL_ITERS / 2);

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_SAMPLE, S_CONV, S_CAL, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NBITS-1:0]     result_q, result_d;
  logic [NBITS-1:0]     mask_q, mask_d;
  logic [TRIM_BITS-1:0] trim_val_q, trim_val_d;
  logic [TRIM_BITS-1:0] trim_mask_q, trim_mask_d;
  logic [ONW-1:0]       ones_q, ones_d;
  logic [ITW-1:0]       itt_q, itt_d;
  logic [SCW-1:0]       scnt_q, scnt_d;
  logic                 calibrate_q, calibrate_d;
  logic                 last_cal_q, last_cal_d;
  logic                 en_clkc_q, en_clkc_d;
  logic [ONW-1:0]       ones_sum;

  // Vote total including the current decision; cannot exceed CAL_ITERS.
  assign ones_sum = ones_q + ONW'(comp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_INIT;
      result_q    <= '0;
      mask_q      <= '0;
      trim_val_q  <= '0;
      trim_mask_q <= '0;
      ones_q      <= '0;
      itt_q       <= '0;
      scnt_q      <= '0;
      calibrate_q <= 1'b0;
      last_cal_q  <= 1'b0;
      en_clkc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      mask_q      <= mask_d;
      trim_val_q  <= trim_val_d;
      trim_mask_q <= trim_mask_d;
      ones_q      <= ones_d;
      itt_q       <= itt_d;
      scnt_q      <= scnt_d;
      calibrate_q <= calibrate_d;
      last_cal_q  <= last_cal_d;
      en_clkc_q   <= en_clkc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    mask_d      = mask_q;
    trim_val_d  = trim_val_q;
    trim_mask_d = trim_mask_q;
    ones_d      = ones_q;
    itt_d       = itt_q;
    scnt_d      = scnt_q;
    calibrate_d = calibrate_q;
    last_cal_d  = last_cal_q;
    en_clkc_d   = en_clkc_q;

    case (state_q)
      S_INIT: begin
        trim_val_d = TMSB;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (en) begin
          result_d    = '0;
          mask_d      = MSB;
          calibrate_d = cal;
          en_clkc_d   = 1'b1;
          scnt_d      = '0;
          state_d     = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (scnt_q == SC_LAST) begin
          if (calibrate_q) begin
            trim_val_d  = '0;
            trim_mask_d = TMSB;
            ones_d      = '0;
            itt_d       = '0;
            mask_d      = '0;
            state_d     = S_CAL;
          end else begin
            // Back-to-back conversions keep the old code visible until here.
            result_d = '0;
            state_d  = S_CONV;
          end
        end else begin
          scnt_d = scnt_q + SCW'(1);
        end
      end

      S_CONV: begin
        if (comp) result_d = result_q | mask_q;
        mask_d = mask_q >> 1;
        if (mask_q[0]) begin
          en_clkc_d  = 1'b0;
          last_cal_d = 1'b0;
          state_d    = S_DONE;
        end
      end

      S_CAL: begin
        if (itt_q == IT_LAST) begin
          // Zeros must strictly win to set the bit; a tie leaves it clear.
          if (ones_sum < HALF) trim_val_d = trim_val_q | trim_mask_q;
          trim_mask_d = trim_mask_q >> 1;
          ones_d      = '0;
          itt_d       = '0;
          if (trim_mask_q[0]) begin
            calibrate_d = 1'b0;
            last_cal_d  = 1'b1;
            en_clkc_d   = 1'b0;
            state_d     = S_DONE;
          end
        end else begin
          ones_d = ones_sum;
          itt_d  = itt_q + ITW'(1);
        end
      end

      S_DONE: begin
        if (ready) begin
          if (cont && !last_cal_q) begin
            mask_d    = MSB;
            en_clkc_d = 1'b1;
            scnt_d    = '0;
            state_d   = S_SAMPLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  assign valid    = (state_q == S_DONE);
  assign result   = result_q;
  assign ctlp     = result_q | mask_q;
  assign ctln     = ~(result_q | mask_q);
  assign trim     = trim_val_q | trim_mask_q;
  assign trimb    = ~(trim_val_q | trim_mask_q);
  assign sample   = (state_q == S_SAMPLE) || (state_q == S_CAL);
  assign cal_busy = (state_q == S_CAL);
  // en_clkc only moves on the rising edge, so gating with the low phase is glitch-free.
  assign clkc     = ~clk & en_clkc_q;

endmodule

// File: tb/tb_sar_logic_gen2.sv
// Bench for sar_logic_gen2: an ideal comparator converts a random input voltage,
// calibration votes come from stored patterns, a scoreboard checks every handshake.
module tb_sar_logic_gen2;

  localparam int unsigned NB      = 8;
  localparam int unsigned TW      = 5;
  localparam int unsigned CI      = 8;
  localparam int unsigned SC      = 1;
  localparam int unsigned CAL_LEN = TW * CI;
  localparam logic [31:0] NB_ONES = 32'((64'd1 << NB) - 1);
  localparam logic [31:0] TW_ONES = 32'((64'd1 << TW) - 1);
  localparam logic [31:0] TMID    = 32'(64'd1 << (TW - 1));

  typedef struct packed {
    logic        is_cal;
    logic [31:0] value;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn, en, cal, cont, comp, ready;
  logic          valid, sample, cal_busy, clkc;
  logic [NB-1:0] result, ctlp, ctln;
  logic [TW-1:0] trim, trimb;

  int            passed = 0;
  int            total = 0;
  exp_t          exp_q[$];
  logic [NB-1:0] vin = '0;
  bit            pat[CAL_LEN];
  int            clkc_cnt = 0;
  int            busy_cnt = 0;

  always #5 clk = ~clk;

  sar_logic_gen2 #(
    .NBITS(NB), .TRIM_BITS(TW), .CAL_ITERS(CI), .SAMPLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .cal(cal), .cont(cont), .comp(comp),
    .ready(ready), .valid(valid), .result(result), .sample(sample),
    .ctlp(ctlp), .ctln(ctln), .trim(trim), .trimb(trimb),
    .cal_busy(cal_busy), .clkc(clkc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Trim bit k (MSB first) is set when fewer than half of its votes are ones.
  function automatic logic [31:0] model_trim();
    logic [31:0] t = '0;
    for (int b = 0; b < int'(TW); b++) begin
      int ones = 0;
      for (int i = 0; i < int'(CI); i++) ones += int'(pat[b*CI+i]);
      if (ones * 2 < int'(CI)) t[TW-1-b] = 1'b1;
    end
    return t;
  endfunction

  // Raise en (cycle 1 is the edge that samples it) and count cycles until valid.
  task automatic start_op(input logic c, output int lat);
    en  = 1'b1;
    cal = c;
    tick();
    en  = 1'b0;
    cal = 1'b0;
    lat = 1;
    while (!valid && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  // Comparator: pattern-driven during calibration, ideal vin >= DAC level otherwise.
  initial begin
    int k;
    k    = 0;
    comp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cal_busy) begin
        comp = (k < int'(CAL_LEN)) ? pat[k] : 1'b0;
        k++;
      end else begin
        k    = 0;
        comp = (vin >= ctlp);
      end
    end
  end

  initial forever begin
    @(posedge clkc);
    clkc_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (cal_busy) busy_cnt++;
  end

  // Scoreboard monitor: compare on every accepted transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rstn && valid && ready) begin
        chk("expect_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.is_cal) chk("sb_trim", 32'(trim), e.value);
          else          chk("sb_result", 32'(result), e.value);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, gap, c0, b0, w, stall;
    rstn = 1'b0; en = 1'b0; cal = 1'b0; cont = 1'b0; ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_clkc", 32'(clkc), 0);
    chk("rst_cal_busy", 32'(cal_busy), 0);
    chk("rst_ctlp", 32'(ctlp), 0);
    chk("rst_ctln", 32'(ctln), NB_ONES);
    chk("rst_trim", 32'(trim), 0);
    chk("rst_trimb", 32'(trimb), TW_ONES);
    rstn = 1'b1;
    tick();
    chk("init_trim_mid", 32'(trim), TMID);

    // Single conversion held under backpressure.
    ready = 1'b0;
    vin   = 8'hB2;
    exp_q.push_back('{is_cal: 1'b0, value: 32'hB2});
    c0 = clkc_cnt;
    start_op(1'b0, lat);
    chk("conv_latency", 32'(lat), 32'(1 + SC + NB));
    chk("conv_clkc_pulses", 32'(clkc_cnt - c0), 32'(SC + NB));
    chk("done_ctlp", 32'(ctlp), 32'hB2);
    c0 = clkc_cnt;
    repeat (5) begin
      tick();
      chk("stall_valid", 32'(valid), 1);
      chk("stall_result", 32'(result), 32'hB2);
    end
    chk("stall_clkc", 32'(clkc_cnt - c0), 0);
    ready = 1'b1;
    tick();
    chk("ack_valid_low", 32'(valid), 0);

    // Continuous mode: full scale then zero, no WAIT between.
    cont = 1'b1;
    vin  = 8'hFF;
    exp_q.push_back('{is_cal: 1'b0, value: 32'hFF});
    exp_q.push_back('{is_cal: 1'b0, value: 32'h00});
    start_op(1'b0, lat);
    chk("cont_latency", 32'(lat), 32'(1 + SC + NB));
    vin = 8'h00;
    tick();
    chk("cont_resample", 32'(sample), 1);
    cont = 1'b0;
    gap = 1;
    while (!valid && gap < 400) begin
      tick();
      gap++;
    end
    chk("cont_gap", 32'(gap), 32'(1 + SC + NB));
    tick();
    chk("cont_end_valid", 32'(valid), 0);

    // Random conversions with random backpressure.
    for (int n = 0; n < 6; n++) begin
      vin   = NB'($urandom);
      ready = 1'b0;
      exp_q.push_back('{is_cal: 1'b0, value: 32'(vin)});
      start_op(1'b0, lat);
      chk("rand_latency", 32'(lat), 32'(1 + SC + NB));
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin
        tick();
        chk("rand_stall_result", 32'(result), 32'(vin));
      end
      ready = 1'b1;
      tick();
    end

    // Calibration: all zeros, alternating, 3 of 8, random.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < int'(CAL_LEN); i++) begin
        case (p)
          0:       pat[i] = 1'b0;
          1:       pat[i] = (i % 2 == 0);
          2:       pat[i] = ((i % int'(CI)) < 3);
          default: pat[i] = 1'($urandom);
        endcase
      end
      exp_q.push_back('{is_cal: 1'b1, value: model_trim()});
      b0 = busy_cnt;
      start_op(1'b1, lat);
      chk("cal_latency", 32'(lat), 32'(1 + SC + CAL_LEN));
      chk("cal_busy_cycles", 32'(busy_cnt - b0), 32'(CAL_LEN));
      chk("cal_done_ctlp", 32'(ctlp), 0);
      chk("cal_trimb", 32'(trimb), ~model_trim() & TW_ONES);
      tick();
      chk("cal_end_valid", 32'(valid), 0);
    end

    // Reset in the middle of a conversion.
    vin = NB'($urandom);
    exp_q.push_back('{is_cal: 1'b0, value: 32'(vin)});
    en = 1'b1;
    tick();
    en = 1'b0;
    tick(4);
    rstn = 1'b0;
    #1;
    exp_q.delete();
    chk("midconv_rst_valid", 32'(valid), 0);
    chk("midconv_rst_sample", 32'(sample), 0);
    chk("midconv_rst_ctlp", 32'(ctlp), 0);
    chk("midconv_rst_ctln", 32'(ctln), NB_ONES);
    chk("midconv_rst_trim", 32'(trim), 0);
    #4;
    chk("midconv_rst_clkc", 32'(clkc), 0);
    @(posedge clk);
    #1;
    tick(2);
    rstn = 1'b1;
    tick();
    chk("midconv_init_trim", 32'(trim), TMID);

    // Reset during the 17th calibration cycle, then a normal conversion.
    for (int i = 0; i < int'(CAL_LEN); i++) pat[i] = 1'($urandom);
    en  = 1'b1;
    cal = 1'b1;
    tick();
    en  = 1'b0;
    cal = 1'b0;
    w = 0;
    while (!cal_busy && w < 20) begin
      tick();
      w++;
    end
    chk("cal_entry", 32'(cal_busy), 1);
    tick(16);
    rstn = 1'b0;
    #1;
    chk("midcal_rst_trim", 32'(trim), 0);
    chk("midcal_rst_busy", 32'(cal_busy), 0);
    #4;
    chk("midcal_rst_clkc", 32'(clkc), 0);
    @(posedge clk);
    #1;
    tick(2);
    rstn = 1'b1;
    tick();
    chk("midcal_init_trim", 32'(trim), TMID);
    vin = NB'($urandom);
    exp_q.push_back('{is_cal: 1'b0, value: 32'(vin)});
    start_op(1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'(1 + SC + NB));
    tick(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
